kmeans_center_update: RTL and testbench
=======================================

# kmeans_center_update

Upstream neighbour of the k-means convergence check. It accumulates per-cluster coordinate sums and point counts over one assignment pass. At pass end it computes the new center of each of the 8 clusters as floor(sum/count) on a shared sequential divider. It then publishes all 16 center coordinates at once together with a one-cycle `updateCenters` pulse, which the convergence check samples.

## Interface
- `WIDTH`, 8, coordinate width; must match the codebase `WIDTH`.
- `CNT_W`, 16, per-cluster point-count width. Derived: `SUM_W = WIDTH + CNT_W`.
- Reset is `rst`, synchronous, active-high; clock is `clk`.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `init_we`  in  1  load one initial center; accepted in IDLE only
- `init_idx`  in  3  cluster index for `init_we`
- `init_x`, `init_y`  in  WIDTH  initial center coordinates
- `start`  in  1  begin a pass; accepted in IDLE only
- `pt_valid`  in  1  assigned point present
- `pt_x`, `pt_y`  in  WIDTH  point coordinates
- `pt_cluster`  in  3  cluster the point was assigned to
- `pass_end`  in  1  last point of the pass is on, or was on, the inputs
- `center0x`..`center7x`, `center0y`..`center7y`  out  WIDTH  registered published centers
- `updateCenters`  out  1  one-cycle pulse; the centers carry the new values in this cycle
- `busy`  out  1  high whenever not in IDLE

## Operation
- FSM states: IDLE, ACCUM, DIVIDE, PUBLISH.
- IDLE
  - `init_we` writes `init_x`/`init_y` into both the center output and the shadow register of cluster `init_idx`.
  - `start` clears all sums and counts and moves to ACCUM.
  - If `init_we` and `start` arrive together, both take effect.
- ACCUM
  - Each `pt_valid` adds `pt_x`/`pt_y` to `sumx`/`sumy[pt_cluster]` and increments `count[pt_cluster]`.
  - If a count is already at 2^CNT_W-1, the point is dropped and neither sum nor count changes.
  - `pass_end` moves to DIVIDE. A `pt_valid` in the same cycle is still accumulated.
- DIVIDE: 16 slots in order 0x, 0y, 1x, 1y, …, 7y.
  - Non-empty cluster: 1 load cycle plus SUM_W restoring-division iterations (one quotient bit per iteration), so SUM_W+1 cycles per slot.
  - Empty cluster (count 0): 1-cycle slot; the shadow register keeps its old value.
  - The quotient always fits in WIDTH. Its low WIDTH bits go to the shadow register; division truncates.
- PUBLISH: one cycle.
  - All 16 shadow registers are copied into the center outputs on the edge that enters PUBLISH.
  - `updateCenters` = 1 for that cycle, then the FSM returns to IDLE.
- `start` and `init_we` are ignored outside IDLE.
- `pt_valid` is ignored outside ACCUM.
- `pass_end` is ignored outside ACCUM.

## Timing
- Reset values: all centers 0, `updateCenters` 0, `busy` 0, sums, counts and shadows 0, state IDLE.
- `rst` mid-pass or mid-DIVIDE aborts immediately. No `updateCenters` follows, and centers return to 0.
- `start` at cycle S: ACCUM from S+1, and `busy` = 1 from S+1.
- `pass_end` at cycle T: DIVIDE starts at T+1. `updateCenters` rises at T+1+L, where L = Σ slot lengths. With all clusters non-empty, L = 16·(SUM_W+1).
- Centers are stable from the `updateCenters` cycle until the next PUBLISH, `init_we`, or `rst`.
- `busy` falls in the cycle after PUBLISH.

## Structure
- Shared package holds:
  - FSM state encoding
  - `NUM_CLUSTERS = 8`
  - `CID_W = 3`
  - the `SUM_W` derivation
- Sub-module `seq_divider`: restoring divider, SUM_W dividend, CNT_W divisor.
  - Ports: `load`, `dividend`, `divisor`, `quotient`, `done`.
  - Fixed latency SUM_W cycles after `load`.
- Top-level holds: accumulator arrays, slot counter, shadow registers, FSM.

## Test plan
- Init, empty clusters, latency (WIDTH=8, CNT_W=16).
  - Stimulus: init all centers to (i·10, i·10); cluster 0 receives points (10,20), (20,40), (31,61); then `pass_end`.
  - Required: center0 = (20,40); centers 1–7 unchanged; `updateCenters` at T+1+2·25+14 = T+65.
- Truncation.
  - Stimulus: cluster 5 receives (255,255) and (254,0).
  - Required: center5 = (254,127).
- Same-cycle `pt_valid` with `pass_end`.
  - Stimulus: the single point (7,9) for cluster 3 arrives with `pass_end`.
  - Required: center3 = (7,9).
- Reset during DIVIDE.
  - Stimulus: `rst` 5 cycles after `pass_end`.
  - Required: no `updateCenters`; all centers 0; `busy` 0 next cycle.
- Ignored inputs.
  - Stimulus: `start` and `init_we` asserted while `busy`.
  - Required: sums unchanged; the published result equals that of the undisturbed run.
- Two identical passes fed into the convergence check.
  - Required: second `updateCenters` produces `done` = 1 on the following cycle.

Source files
------------

// File: rtl/kmeans_center_update_pkg.sv
// Shared constants, width derivation and FSM encoding for the center-update block.
package kmeans_center_update_pkg;

  localparam int unsigned NUM_CLUSTERS = 8;
  localparam int unsigned CID_W        = 3;
  localparam int unsigned NUM_SLOTS    = 2 * NUM_CLUSTERS;
  localparam int unsigned SLOT_W       = 4;

  // Accumulator width: a coordinate times the largest point count must fit.
  function automatic int unsigned sum_width(input int unsigned width, input int unsigned cnt_w);
    return width + cnt_w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DIVIDE  = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

endpackage

// File: rtl/kmeans_center_update_seq_divider.sv
// Restoring divider: one quotient bit per cycle, the first bit is produced on the load edge,
// so the quotient is final and done pulses SUM_W cycles after load.
module seq_divider #(
  parameter int unsigned SUM_W = 24,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned Q_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [Q_W-1:0]   quotient,
  output logic             done
);

  localparam int unsigned CTR_W = $clog2(SUM_W + 1);

  logic [CNT_W-1:0] rem_q;
  logic [SUM_W-1:0] quo_q;
  logic [CNT_W-1:0] dvs_q;
  logic [CTR_W-1:0] cnt_q;
  logic             done_q;

  logic [CNT_W-1:0] src_rem;
  logic [SUM_W-1:0] src_quo;
  logic [CNT_W-1:0] src_dvs;
  logic [CNT_W:0]   shifted;
  logic             fits;
  logic [CNT_W-1:0] rem_nxt;
  logic [SUM_W-1:0] quo_nxt;

  // One restoring step, fed from the operands on load and from the partial state otherwise.
  always_comb begin
    src_rem = load ? '0       : rem_q;
    src_quo = load ? dividend : quo_q;
    src_dvs = load ? divisor  : dvs_q;
    shifted = {src_rem, src_quo[SUM_W-1]};
    fits    = (shifted >= {1'b0, src_dvs});
    rem_nxt = fits ? CNT_W'(shifted - {1'b0, src_dvs}) : shifted[CNT_W-1:0];
    quo_nxt = {src_quo[SUM_W-2:0], fits};
  end

  // Iteration state and end-of-division pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (load) begin
      rem_q  <= rem_nxt;
      quo_q  <= quo_nxt;
      dvs_q  <= divisor;
      cnt_q  <= CTR_W'(SUM_W - 1);
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      rem_q  <= rem_nxt;
      quo_q  <= quo_nxt;
      cnt_q  <= cnt_q - CTR_W'(1);
      done_q <= (cnt_q == CTR_W'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign quotient = quo_q[Q_W-1:0];
  assign done     = done_q;

endmodule

// File: rtl/kmeans_center_update.sv
// Accumulates per-cluster sums/counts over a pass, divides them into new centers on one
// shared divider, and publishes all centers together with a one-cycle updateCenters pulse.
module kmeans_center_update
  import kmeans_center_update_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_we,
  input  logic [CID_W-1:0] init_idx,
  input  logic [WIDTH-1:0] init_x,
  input  logic [WIDTH-1:0] init_y,
  input  logic             start,
  input  logic             pt_valid,
  input  logic [WIDTH-1:0] pt_x,
  input  logic [WIDTH-1:0] pt_y,
  input  logic [CID_W-1:0] pt_cluster,
  input  logic             pass_end,
  output logic [WIDTH-1:0] center0x,
  output logic [WIDTH-1:0] center1x,
  output logic [WIDTH-1:0] center2x,
  output logic [WIDTH-1:0] center3x,
  output logic [WIDTH-1:0] center4x,
  output logic [WIDTH-1:0] center5x,
  output logic [WIDTH-1:0] center6x,
  output logic [WIDTH-1:0] center7x,
  output logic [WIDTH-1:0] center0y,
  output logic [WIDTH-1:0] center1y,
  output logic [WIDTH-1:0] center2y,
  output logic [WIDTH-1:0] center3y,
  output logic [WIDTH-1:0] center4y,
  output logic [WIDTH-1:0] center5y,
  output logic [WIDTH-1:0] center6y,
  output logic [WIDTH-1:0] center7y,
  output logic             updateCenters,
  output logic             busy
);

  localparam int unsigned SUM_W = sum_width(WIDTH, CNT_W);

  state_t state_q, state_nxt;

  logic [SUM_W-1:0]  sum_x [NUM_CLUSTERS];
  logic [SUM_W-1:0]  sum_y [NUM_CLUSTERS];
  logic [CNT_W-1:0]  count [NUM_CLUSTERS];
  logic [WIDTH-1:0]  shadow_x [NUM_CLUSTERS];
  logic [WIDTH-1:0]  shadow_y [NUM_CLUSTERS];
  logic [WIDTH-1:0]  shadow_x_nxt [NUM_CLUSTERS];
  logic [WIDTH-1:0]  shadow_y_nxt [NUM_CLUSTERS];
  logic [WIDTH-1:0]  cen_x [NUM_CLUSTERS];
  logic [WIDTH-1:0]  cen_y [NUM_CLUSTERS];

  logic [SLOT_W-1:0] slot_q;
  logic              div_active_q;
  logic              update_q;
  logic              busy_q;

  logic [CID_W-1:0]  slot_cid;
  logic              slot_is_y;
  logic              slot_empty;
  logic [SUM_W-1:0]  div_dividend;
  logic [WIDTH-1:0]  div_quo;
  logic              div_done;
  logic              div_load_c;
  logic              slot_done_c;
  logic              shadow_we_c;

  // Slot decode: slot order is 0x, 0y, 1x, 1y, ... so the cluster is the upper slot bits.
  always_comb begin
    slot_cid     = slot_q[SLOT_W-1:1];
    slot_is_y    = slot_q[0];
    slot_empty   = (count[slot_cid] == '0);
    div_dividend = slot_is_y ? sum_y[slot_cid] : sum_x[slot_cid];
  end

  seq_divider #(
    .SUM_W (SUM_W),
    .CNT_W (CNT_W),
    .Q_W   (WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load_c),
    .dividend (div_dividend),
    .divisor  (count[slot_cid]),
    .quotient (div_quo),
    .done     (div_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  // Next state and per-cycle divide-slot control.
  always_comb begin
    state_nxt   = state_q;
    div_load_c  = 1'b0;
    slot_done_c = 1'b0;
    shadow_we_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (pass_end) state_nxt = ST_DIVIDE;
      end
      ST_DIVIDE: begin
        if (!div_active_q) begin
          if (slot_empty) slot_done_c = 1'b1;
          else            div_load_c  = 1'b1;
        end else if (div_done) begin
          shadow_we_c = 1'b1;
          slot_done_c = 1'b1;
        end
        if (slot_done_c && (slot_q == SLOT_W'(NUM_SLOTS - 1))) state_nxt = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shadow next values: initial loads in IDLE, quotients at the end of each busy slot.
  always_comb begin
    shadow_x_nxt = shadow_x;
    shadow_y_nxt = shadow_y;
    if ((state_q == ST_IDLE) && init_we) begin
      shadow_x_nxt[init_idx] = init_x;
      shadow_y_nxt[init_idx] = init_y;
    end
    if (shadow_we_c) begin
      if (slot_is_y) shadow_y_nxt[slot_cid] = div_quo;
      else           shadow_x_nxt[slot_cid] = div_quo;
    end
  end

  // Datapath: accumulators, slot sequencing, shadows, published centers and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLUSTERS; i++) begin
        sum_x[i]    <= '0;
        sum_y[i]    <= '0;
        count[i]    <= '0;
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
        cen_x[i]    <= '0;
        cen_y[i]    <= '0;
      end
      slot_q       <= '0;
      div_active_q <= 1'b0;
      update_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      shadow_x <= shadow_x_nxt;
      shadow_y <= shadow_y_nxt;
      case (state_q)
        ST_IDLE: begin
          slot_q       <= '0;
          div_active_q <= 1'b0;
          if (init_we) begin
            cen_x[init_idx] <= init_x;
            cen_y[init_idx] <= init_y;
          end
          if (start) begin
            for (int i = 0; i < NUM_CLUSTERS; i++) begin
              sum_x[i] <= '0;
              sum_y[i] <= '0;
              count[i] <= '0;
            end
          end
        end
        ST_ACCUM: begin
          // A saturated count drops the point entirely so sum/count stay consistent.
          if (pt_valid && (count[pt_cluster] != '1)) begin
            sum_x[pt_cluster] <= sum_x[pt_cluster] + SUM_W'(pt_x);
            sum_y[pt_cluster] <= sum_y[pt_cluster] + SUM_W'(pt_y);
            count[pt_cluster] <= count[pt_cluster] + CNT_W'(1);
          end
        end
        ST_DIVIDE: begin
          if (div_load_c) div_active_q <= 1'b1;
          if (slot_done_c) begin
            div_active_q <= 1'b0;
            slot_q       <= slot_q + SLOT_W'(1);
          end
        end
        default: ;
      endcase
      // Copy the shadows including the final quotient written on this same edge.
      if (state_nxt == ST_PUBLISH) begin
        cen_x <= shadow_x_nxt;
        cen_y <= shadow_y_nxt;
      end
      update_q <= (state_nxt == ST_PUBLISH);
      busy_q   <= (state_nxt != ST_IDLE);
    end
  end

  assign updateCenters = update_q;
  assign busy          = busy_q;

  assign center0x = cen_x[0];
  assign center1x = cen_x[1];
  assign center2x = cen_x[2];
  assign center3x = cen_x[3];
  assign center4x = cen_x[4];
  assign center5x = cen_x[5];
  assign center6x = cen_x[6];
  assign center7x = cen_x[7];
  assign center0y = cen_y[0];
  assign center1y = cen_y[1];
  assign center2y = cen_y[2];
  assign center3y = cen_y[3];
  assign center4y = cen_y[4];
  assign center5y = cen_y[5];
  assign center6y = cen_y[6];
  assign center7y = cen_y[7];

endmodule

// File: tb/tb_kmeans_center_update.sv
// Directed bench for kmeans_center_update with hand-computed expected centers and latencies.
module tb_kmeans_center_update;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_we;
  logic [2:0] init_idx;
  logic [7:0] init_x, init_y;
  logic       start;
  logic       pt_valid;
  logic [7:0] pt_x, pt_y;
  logic [2:0] pt_cluster;
  logic       pass_end;
  logic [7:0] cx [8];
  logic [7:0] cy [8];
  logic       updateCenters;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int n;
  int seen;
  logic [7:0] snap_x [8];
  logic [7:0] snap_y [8];
  logic       flag;

  always #5 clk = ~clk;

  kmeans_center_update dut (
    .clk (clk), .rst (rst),
    .init_we (init_we), .init_idx (init_idx), .init_x (init_x), .init_y (init_y),
    .start (start), .pt_valid (pt_valid), .pt_x (pt_x), .pt_y (pt_y),
    .pt_cluster (pt_cluster), .pass_end (pass_end),
    .center0x (cx[0]), .center1x (cx[1]), .center2x (cx[2]), .center3x (cx[3]),
    .center4x (cx[4]), .center5x (cx[5]), .center6x (cx[6]), .center7x (cx[7]),
    .center0y (cy[0]), .center1y (cy[1]), .center2y (cy[2]), .center3y (cy[3]),
    .center4y (cy[4]), .center5y (cy[5]), .center6y (cy[6]), .center7y (cy[7]),
    .updateCenters (updateCenters), .busy (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles from the current sample point until updateCenters is seen (bounded).
  task automatic wait_update(output int cycles);
    cycles = 0;
    while (updateCenters !== 1'b1 && cycles < 3000) begin
      tick();
      cycles++;
    end
  endtask

  task automatic point(input logic [2:0] c, input logic [7:0] x, input logic [7:0] y);
    pt_valid = 1'b1; pt_cluster = c; pt_x = x; pt_y = y;
    tick();
    pt_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_pass_end();
    pass_end = 1'b1;
    tick();
    pass_end = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init_we = 1'b0; init_idx = '0; init_x = '0; init_y = '0;
    start = 1'b0; pt_valid = 1'b0; pt_x = '0; pt_y = '0; pt_cluster = '0; pass_end = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_upd", 32'(updateCenters), 0);
    chk("rst_c0x", 32'(cx[0]), 0);
    chk("rst_c7y", 32'(cy[7]), 0);

    // Initial centers (i*10, i*10)
    for (int i = 0; i < 8; i++) begin
      init_we = 1'b1; init_idx = 3'(i); init_x = 8'(i * 10); init_y = 8'(i * 10);
      tick();
    end
    init_we = 1'b0;
    chk("init_c3x", 32'(cx[3]), 30);
    chk("init_c7y", 32'(cy[7]), 70);

    // Pass 1: cluster 0 gets (10,20),(20,40),(31,61) -> (20,40); latency T+65
    do_start();
    chk("start_busy", 32'(busy), 1);
    point(3'd0, 8'd10, 8'd20);
    point(3'd0, 8'd20, 8'd40);
    point(3'd0, 8'd31, 8'd61);
    do_pass_end();
    wait_update(n);
    chk("p1_latency", 32'(n + 1), 65);
    chk("p1_c0x", 32'(cx[0]), 20);
    chk("p1_c0y", 32'(cy[0]), 40);
    chk("p1_c1x", 32'(cx[1]), 10);
    chk("p1_c7y", 32'(cy[7]), 70);
    chk("p1_busy_pub", 32'(busy), 1);
    tick();
    chk("p1_upd_pulse", 32'(updateCenters), 0);
    chk("p1_busy_fall", 32'(busy), 0);

    // Pass 2: truncation on cluster 5; init_we together with start in IDLE
    init_we = 1'b1; init_idx = 3'd6; init_x = 8'd66; init_y = 8'd67;
    do_start();
    init_we = 1'b0;
    chk("init_start_c6x", 32'(cx[6]), 66);
    point(3'd5, 8'd255, 8'd255);
    point(3'd5, 8'd254, 8'd0);
    do_pass_end();
    wait_update(n);
    chk("p2_latency", 32'(n + 1), 65);
    chk("p2_c5x", 32'(cx[5]), 254);
    chk("p2_c5y", 32'(cy[5]), 127);
    chk("p2_c0x_kept", 32'(cx[0]), 20);
    chk("p2_c6y_kept", 32'(cy[6]), 67);
    tick();

    // Pass 3: single point arrives with pass_end
    do_start();
    pt_valid = 1'b1; pt_cluster = 3'd3; pt_x = 8'd7; pt_y = 8'd9; pass_end = 1'b1;
    tick();
    pt_valid = 1'b0; pass_end = 1'b0;
    wait_update(n);
    chk("p3_latency", 32'(n + 1), 65);
    chk("p3_c3x", 32'(cx[3]), 7);
    chk("p3_c3y", 32'(cy[3]), 9);
    tick();

    // Pass 4: undisturbed reference on cluster 2 -> (51,26)
    do_start();
    point(3'd2, 8'd100, 8'd50);
    point(3'd2, 8'd50, 8'd25);
    point(3'd2, 8'd3, 8'd4);
    do_pass_end();
    wait_update(n);
    chk("p4_c2x", 32'(cx[2]), 51);
    chk("p4_c2y", 32'(cy[2]), 26);
    tick();

    // Pass 5: same points with start/init_we in ACCUM and stray inputs in DIVIDE
    do_start();
    point(3'd2, 8'd100, 8'd50);
    start = 1'b1;
    point(3'd2, 8'd50, 8'd25);
    start = 1'b0;
    init_we = 1'b1; init_idx = 3'd2; init_x = 8'd200; init_y = 8'd201;
    point(3'd2, 8'd3, 8'd4);
    init_we = 1'b0;
    chk("busy_init_ignored", 32'(cx[2]), 51);
    do_pass_end();
    tick(); tick(); tick();
    start = 1'b1; init_we = 1'b1; pass_end = 1'b1;
    point(3'd2, 8'd255, 8'd255);
    start = 1'b0; init_we = 1'b0; pass_end = 1'b0;
    wait_update(n);
    chk("p5_upd_seen", 32'(updateCenters), 1);
    chk("p5_c2x", 32'(cx[2]), 51);
    chk("p5_c2y", 32'(cy[2]), 26);
    tick();

    // Two identical passes on cluster 1 -> (40,40); second result must equal the first
    for (int p = 0; p < 2; p++) begin
      do_start();
      point(3'd1, 8'd30, 8'd50);
      point(3'd1, 8'd50, 8'd30);
      do_pass_end();
      wait_update(n);
      if (p == 0) begin
        for (int i = 0; i < 8; i++) begin
          snap_x[i] = cx[i];
          snap_y[i] = cy[i];
        end
      end
      tick();
    end
    chk("conv_c1x", 32'(cx[1]), 40);
    chk("conv_c1y", 32'(cy[1]), 40);
    flag = 1'b1;
    for (int i = 0; i < 8; i++)
      if (cx[i] !== snap_x[i] || cy[i] !== snap_y[i]) flag = 1'b0;
    chk("conv_done", 32'(flag), 1);

    // Reset 5 cycles after pass_end aborts the pass
    do_start();
    point(3'd4, 8'd9, 8'd9);
    do_pass_end();
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_upd", 32'(updateCenters), 0);
    flag = 1'b0;
    for (int i = 0; i < 8; i++)
      if (cx[i] !== 8'd0 || cy[i] !== 8'd0) flag = 1'b1;
    chk("abort_centers_zero", 32'(flag), 0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (updateCenters === 1'b1) seen++;
    end
    chk("abort_no_update", 32'(seen), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
